// File: rtl/reg_access_sequencer_if.sv
// Bundle of the command, register-file and response channels of reg_access_sequencer.
// master: the sequencer (initiator). slave: control unit and register file side.
interface reg_access_sequencer_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_ra;
  logic [ADDR_WIDTH-1:0] cmd_rb;
  logic [DATA_WIDTH-1:0] cmd_imm;

  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic                  rd0_enable;
  logic [DATA_WIDTH-1:0] rd0_data;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic                  rd1_enable;
  logic [DATA_WIDTH-1:0] rd1_data;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_enable;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data0;
  logic [DATA_WIDTH-1:0] rsp_data1;
  logic                  rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm,
    input  rd0_data, rd1_data, rsp_ready,
    output cmd_ready, rd0_addr, rd0_enable, rd1_addr, rd1_enable,
    output wr_addr, wr_data, wr_enable,
    output rsp_valid, rsp_data0, rsp_data1, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm,
    output rd0_data, rd1_data, rsp_ready,
    input  cmd_ready, rd0_addr, rd0_enable, rd1_addr, rd1_enable,
    input  wr_addr, wr_data, wr_enable,
    input  rsp_valid, rsp_data0, rsp_data1, rsp_err
  );
endinterface

// File: rtl/reg_access_sequencer.sv
// Register-file access sequencer: runs READ/WRITE/COPY/SWAP as fixed port sequences.
// Optional read-back check of every write: define REG_SEQ_WRITE_VERIFY_EN.
module reg_access_sequencer #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_access_sequencer_if.master bus
);

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_COPY, OP_SWAP} op_e;
  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPTURE, WR0, WR1, RESP, VF_ISSUE, VF_CAPTURE
  } state_e;

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] ra_q, rb_q;
  logic [DATA_WIDTH-1:0] imm_q, op0_q, op1_q;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] tgt_addr;
  logic [DATA_WIDTH-1:0] tgt_data;
  logic                  tgt_second;
`ifdef REG_SEQ_WRITE_VERIFY_EN
  logic                  second_q;
  logic                  err_q;
`endif

  assign accept = (state_q == IDLE) && bus.cmd_valid;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the command/operand registers are reset too, so the response outputs read 0 from reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_READ;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
      op0_q <= '0;
      op1_q <= '0;
`ifdef REG_SEQ_WRITE_VERIFY_EN
      second_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q  <= op_e'(bus.cmd_op);
        ra_q  <= bus.cmd_ra;
        rb_q  <= bus.cmd_rb;
        imm_q <= bus.cmd_imm;
      end
      if (state_q == RD_CAPTURE) begin
        op0_q <= bus.rd0_data;
        op1_q <= bus.rd1_data;
      end
`ifdef REG_SEQ_WRITE_VERIFY_EN
      if (accept) begin
        second_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (state_d == WR1) second_q <= 1'b1;
        if (state_q == VF_CAPTURE && bus.rd0_data != tgt_data) err_q <= 1'b1;
      end
`endif
    end
  end

  // Address/data of the write currently in progress (or being verified).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tgt_second = (state_q == WR1);
`ifdef REG_SEQ_WRITE_VERIFY_EN
    if (state_q == VF_ISSUE || state_q == VF_CAPTURE) tgt_second = second_q;
`endif
    tgt_addr = ra_q;
    tgt_data = '0;
    if (tgt_second) begin
      tgt_addr = rb_q;
      tgt_data = op0_q;
    end else begin
      case (op_q)
        OP_WRITE: begin tgt_addr = ra_q; tgt_data = imm_q; end
        OP_COPY:  begin tgt_addr = rb_q; tgt_data = op0_q; end
        OP_SWAP:  begin tgt_addr = ra_q; tgt_data = op1_q; end
        default:  begin tgt_addr = ra_q; tgt_data = '0;    end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.cmd_valid)
                    state_d = (op_e'(bus.cmd_op) == OP_WRITE) ? WR0 : RD_ISSUE;
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = (op_q == OP_READ) ? RESP : WR0;
`ifdef REG_SEQ_WRITE_VERIFY_EN
      WR0:        state_d = VF_ISSUE;
      WR1:        state_d = VF_ISSUE;
      VF_ISSUE:   state_d = VF_CAPTURE;
      VF_CAPTURE: state_d = (op_q == OP_SWAP && !second_q) ? WR1 : RESP;
`else
      WR0:        state_d = (op_q == OP_SWAP) ? WR1 : RESP;
      WR1:        state_d = RESP;
`endif
      RESP:       if (bus.rsp_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = (state_q == IDLE);
    bus.rd0_enable = 1'b0;
    bus.rd0_addr   = '0;
    bus.rd1_enable = 1'b0;
    bus.rd1_addr   = '0;
    bus.wr_enable  = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_data0  = '0;
    bus.rsp_data1  = '0;
    bus.rsp_err    = 1'b0;
    case (state_q)
      RD_ISSUE, RD_CAPTURE: begin
        bus.rd0_enable = 1'b1;
        bus.rd0_addr   = ra_q;
        // COPY only needs its source, so port 1 stays idle.
        if (op_q == OP_READ || op_q == OP_SWAP) begin
          bus.rd1_enable = 1'b1;
          bus.rd1_addr   = rb_q;
        end
      end
      WR0, WR1: begin
        bus.wr_enable = 1'b1;
        bus.wr_addr   = tgt_addr;
        bus.wr_data   = tgt_data;
      end
      VF_ISSUE, VF_CAPTURE: begin
        bus.rd0_enable = 1'b1;
        bus.rd0_addr   = tgt_addr;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        case (op_q)
          OP_READ:  begin bus.rsp_data0 = op0_q; bus.rsp_data1 = op1_q; end
          OP_WRITE: begin bus.rsp_data0 = imm_q; bus.rsp_data1 = '0;    end
          OP_COPY:  begin bus.rsp_data0 = op0_q; bus.rsp_data1 = '0;    end
          default:  begin bus.rsp_data0 = op0_q; bus.rsp_data1 = op1_q; end
        endcase
`ifdef REG_SEQ_WRITE_VERIFY_EN
        bus.rsp_err = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Scoreboard bench for reg_access_sequencer with a behavioural 8x8 register file.
module tb_reg_access_sequencer;

`ifdef REG_SEQ_WRITE_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif
  localparam int LAT_READ  = 3;
  localparam int LAT_WRITE = 2 + 2 * VF;
  localparam int LAT_COPY  = 4 + 2 * VF;
  localparam int LAT_SWAP  = 5 + 4 * VF;

  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_COPY = 2'd2, OP_SWAP = 2'd3;

  typedef struct {
    string      name;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_pulses = 0;
  logic prev_valid = 1'b0;
  logic corrupt_r4 = 1'b0;
  exp_t exp_q[$];

  logic [7:0] mem [8];
  logic [7:0] rd0_q = '0;
  logic [7:0] rd1_q = '0;

  reg_access_sequencer_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  reg_access_sequencer #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: reads registered one cycle after enable; optional r4 corruption.
  always @(posedge clk) begin
    if (bus.wr_enable)
      mem[bus.wr_addr] <= (corrupt_r4 && bus.wr_addr == 3'd4) ? (bus.wr_data ^ 8'h01) : bus.wr_data;
    if (bus.rd0_enable) rd0_q <= mem[bus.rd0_addr];
    if (bus.rd1_enable) rd1_q <= mem[bus.rd1_addr];
  end
  assign bus.rd0_data = rd0_q;
  assign bus.rd1_data = rd1_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every cycle a response is presented, pops on handshake.
  always @(negedge clk) begin
    if (bus.wr_enable) wr_pulses++;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
      end else begin
        if (!prev_valid) check({exp_q[0].name, ".latency"}, cyc - exp_q[0].acc, exp_q[0].lat);
        check({exp_q[0].name, ".data0"}, {24'b0, bus.rsp_data0}, {24'b0, exp_q[0].d0});
        check({exp_q[0].name, ".data1"}, {24'b0, bus.rsp_data1}, {24'b0, exp_q[0].d1});
        check({exp_q[0].name, ".err"},   {31'b0, bus.rsp_err},   {31'b0, exp_q[0].err});
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
    prev_valid = bus.rsp_valid;
  end

  task automatic drive_cmd(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [7:0] imm);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] imm, input logic [7:0] d0,
                       input logic [7:0] d1, input logic err, input int lat);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    drive_cmd(op, ra, rb, imm);
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      check({name, ".accept_timeout"}, {31'b0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.name = name; e.d0 = d0; e.d1 = d1; e.err = err; e.lat = lat; e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, ".rsp_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [2:0] ra,
                     input logic [2:0] rb, input logic [7:0] imm, input logic [7:0] d0,
                     input logic [7:0] d1, input logic err, input int lat);
    issue(name, op, ra, rb, imm, d0, d1, err, lat);
    wait_done(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset.cmd_ready",  {31'b0, bus.cmd_ready},  32'd1);
    check("reset.rsp_valid",  {31'b0, bus.rsp_valid},  32'd0);
    check("reset.wr_enable",  {31'b0, bus.wr_enable},  32'd0);
    check("reset.rd0_enable", {31'b0, bus.rd0_enable}, 32'd0);
    check("reset.rd1_enable", {31'b0, bus.rd1_enable}, 32'd0);
    check("reset.rsp_data0",  {24'b0, bus.rsp_data0},  32'd0);

    for (int i = 0; i < 8; i++)
      run($sformatf("write_r%0d", i), OP_WRITE, 3'(i), 3'd0, 8'(42 + i), 8'(42 + i), 8'd0, 1'b0, LAT_WRITE);
    for (int i = 0; i < 8; i++)
      run($sformatf("read_%0d_%0d", i, 7 - i), OP_READ, 3'(i), 3'(7 - i), 8'd0,
          8'(42 + i), 8'(49 - i), 1'b0, LAT_READ);

    // SWAP r0/r7 interrupted by reset while its first write is on the port.
    @(negedge clk);
    drive_cmd(OP_SWAP, 3'd0, 3'd7, 8'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.wr_enable && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("mid_swap.wr0_enable", {31'b0, bus.wr_enable}, 32'd1);
    check("mid_swap.wr0_data",   {24'b0, bus.wr_data},   32'd49);
    reset = 1'b0;
    #1;
    check("mid_swap.wr_enable_drop", {31'b0, bus.wr_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_swap.no_wr1",    {31'b0, bus.wr_enable}, 32'd0);
    check("mid_swap.cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    run("read_after_abort", OP_READ, 3'd0, 3'd7, 8'd0, 8'd42, 8'd49, 1'b0, LAT_READ);

    run("write_r3_5a", OP_WRITE, 3'd3, 3'd0, 8'h5A, 8'h5A, 8'h00, 1'b0, LAT_WRITE);
    run("copy_3_to_6", OP_COPY,  3'd3, 3'd6, 8'h00, 8'h5A, 8'h00, 1'b0, LAT_COPY);
    run("read_6_3",    OP_READ,  3'd6, 3'd3, 8'h00, 8'h5A, 8'h5A, 1'b0, LAT_READ);

    p0 = wr_pulses;
    run("swap_1_2", OP_SWAP, 3'd1, 3'd2, 8'd0, 8'd43, 8'd44, 1'b0, LAT_SWAP);
    check("swap_1_2.wr_pulses", wr_pulses - p0, 32'd2);
    run("read_1_2", OP_READ, 3'd1, 3'd2, 8'd0, 8'd44, 8'd43, 1'b0, LAT_READ);

    p0 = wr_pulses;
    run("swap_5_5", OP_SWAP, 3'd5, 3'd5, 8'd0, 8'd47, 8'd47, 1'b0, LAT_SWAP);
    check("swap_5_5.wr_pulses", wr_pulses - p0, 32'd2);
    run("read_5_5", OP_READ, 3'd5, 3'd5, 8'd0, 8'd47, 8'd47, 1'b0, LAT_READ);

    // Backpressure: response must hold while a competing command is offered.
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue("bp_read_0", OP_READ, 3'd0, 3'd0, 8'd0, 8'd42, 8'd42, 1'b0, LAT_READ);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cmd(OP_WRITE, 3'd0, 3'd0, 8'hFF);
      check("bp.cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
      check("bp.rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_done("bp_read_0");
    run("read_0_after_bp", OP_READ, 3'd0, 3'd0, 8'd0, 8'd42, 8'd42, 1'b0, LAT_READ);

    // Faulty register file at r4: only the verify build reports it.
    corrupt_r4 = 1'b1;
    run("verify_write_r4", OP_WRITE, 3'd4, 3'd0, 8'h33, 8'h33, 8'h00, VF[0], LAT_WRITE);
    run("verify_write_r5", OP_WRITE, 3'd5, 3'd0, 8'h55, 8'h55, 8'h00, 1'b0,  LAT_WRITE);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
Initiator for the register-file port protocol; the register file is the responder. Accepts one command at a time (READ, WRITE, COPY, SWAP) on a valid/ready interface and drives the register file's two read ports and one write port. Returns the operand values on a valid/ready response interface. Sits between the control unit and register_file, and replaces ad-hoc enable/addr toggling.

Parameters:
ADDR_WIDTH, 3, register index width (8 registers)
DATA_WIDTH, 8, register data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer idle, command accepted when valid&&ready
cmd_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 SWAP
cmd_ra  in  ADDR_WIDTH  source A / write destination for WRITE
cmd_rb  in  ADDR_WIDTH  source B / COPY destination
cmd_imm  in  DATA_WIDTH  WRITE data
rd0_addr, rd0_enable  out  ADDR_WIDTH, 1  read port 0 request (bind to rd0_bus.addr/enable)
rd0_data  in  DATA_WIDTH  read port 0 data (rd0_bus.data)
rd1_addr, rd1_enable  out  ADDR_WIDTH, 1  read port 1 request (rd1_bus)
rd1_data  in  DATA_WIDTH  read port 1 data
wr_addr, wr_data, wr_enable  out  ADDR_WIDTH, DATA_WIDTH, 1  write port (wr_bus)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data0, rsp_data1  out  DATA_WIDTH  response values
rsp_err  out  1  write-verify mismatch (optional feature)

Behaviour:
- Reset (async, reset==0): state IDLE. cmd_ready=1 after release. All enables, addrs, wr_data, rsp_* are 0. An in-flight write is aborted, with no partial second SWAP write.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR0, WR1, RESP (+VF_ISSUE, VF_CAPTURE with the optional feature).
- IDLE: cmd_ready=1. On accept, latch op/ra/rb/imm. WRITE -> WR0; others -> RD_ISSUE. cmd_ready=0 in every other state; cmd_valid is ignored while busy.
- RD_ISSUE, RD_CAPTURE: rd0_enable=1, rd0_addr=ra. rd1_enable=1, rd1_addr=rb for READ/SWAP only; COPY leaves rd1 disabled. Register-file read data is valid one cycle after enable. At the end of RD_CAPTURE, latch op0=rd0_data and op1=rd1_data. Next: READ -> RESP; COPY/SWAP -> WR0.
- WR0 (one cycle, wr_enable=1):
  - WRITE: addr=ra, data=imm.
  - COPY: addr=rb, data=op0.
  - SWAP: addr=ra, data=op1.
  - Next: SWAP -> WR1; else RESP.
- WR1: wr_enable=1, addr=rb, data=op0. Next: RESP.
- Enables are never asserted outside their states. When an enable is low, its addr/data outputs are 0.
- RESP: rsp_valid=1 and holds stable until rsp_ready; then -> IDLE. Response contents:
  - READ: data0=op0, data1=op1.
  - WRITE: data0=imm, data1=0.
  - COPY: data0=op0, data1=0.
  - SWAP: data0=old ra, data1=old rb.
- Latency from the accept edge to rsp_valid: READ 3, WRITE 2, COPY 4, SWAP 5 cycles. The next accept is possible in the cycle after the RESP handshake.
- SWAP with ra==rb performs both writes of the same value; the register is unchanged and data0==data1.
- COPY with ra==rb rewrites the same value.

Optional Feature:
REG_SEQ_WRITE_VERIFY_EN
- Defined: every WR0/WR1 is followed by VF_ISSUE and VF_CAPTURE.
  - These drive rd0 at the written address and compare rd0_data with the written value.
  - A mismatch sets rsp_err=1 for that response; rsp_err clears on the next accept.
  - Latency grows by 2 cycles per write: WRITE 4, COPY 6, SWAP 9.
- Undefined: no verify states, and rsp_err is tied to 0.

Test Plan:
- Reset mid-SWAP: assert reset during WR0 -> wr_enable drops immediately, no WR1 write, cmd_ready=1 after release; register holds its prior value.
- WRITE r0..r7 with imm 42..49, then READ (ra=i, rb=7-i) -> rsp_data0=42+i, rsp_data1=49-i, rsp_valid 3 cycles after accept.
- WRITE r3=0x5A, COPY ra=3 rb=6, READ r6 -> COPY rsp_data0=0x5A; READ rsp_data0=0x5A.
- SWAP ra=1 (43) rb=2 (44), then READ 1,2 -> SWAP response 43/44; READ returns 44/43; exactly 2 wr_enable pulses. SWAP ra=rb=5 leaves r5=47.
- Backpressure: hold rsp_ready=0 for 4 cycles -> rsp_valid and data are stable, cmd_ready=0, and a new cmd_valid is ignored until the handshake.
- Verify on (REG_SEQ_WRITE_VERIFY_EN): the register-file model corrupts writes to r4 -> WRITE r4 gives rsp_err=1, latency 4; WRITE r5 gives rsp_err=0.
